// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Sequencer in front of the UART transmitter. Arbitrates between
//            a flow-control character request (fixed priority) and the TX
//            FIFO, loads the chosen byte, pulses start, waits for frame
//            completion and optionally enforces an inter-frame guard time
//            counted in baud ticks.
// Options  : UART_TX_SCHED_GUARD_EN - include the GUARD state and counter.
//            When undefined, guard_ticks_i and tick_i are unused.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int GUARD_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_en_i,
    input  logic               fifo_empty_i,
    input  logic [7:0]         fifo_data_i,
    output logic               fifo_rd_o,
    input  logic               ctrl_req_i,
    input  logic [7:0]         ctrl_data_i,
    output logic               ctrl_ack_o,
    input  logic [GUARD_W-1:0] guard_ticks_i,
    input  logic               tick_i,
    input  logic               cts_ni,
    input  logic               trans_fi_i,
    output logic               start_tx_o,
    output logic [7:0]         data_o,
    output logic               busy_o
);

`ifdef UART_TX_SCHED_GUARD_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_FI = 3'd3,
        ST_GUARD   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_FI = 3'd3
    } state_t;
`endif

    state_t     r_state_q,    w_state_d;
    logic [7:0] r_data_q,     w_data_d;
    logic       r_src_ctrl_q, w_src_ctrl_d;
    logic       r_fifo_rd_q,  w_fifo_rd_d;
    logic       r_ctrl_ack_q, w_ctrl_ack_d;
    logic       r_start_tx_q, w_start_tx_d;
    logic       r_busy_q,     w_busy_d;

`ifdef UART_TX_SCHED_GUARD_EN
    logic [GUARD_W-1:0] r_guard_cnt_q, w_guard_cnt_d;
    logic [GUARD_W:0]   w_guard_inc;

    assign w_guard_inc = {1'b0, r_guard_cnt_q} + {{GUARD_W{1'b0}}, 1'b1};
`else
    logic w_unused_guard;

    assign w_unused_guard = ^{guard_ticks_i, tick_i};
`endif

    // Next-state, byte latch and registered-output pulse generation
    always_comb begin
        w_state_d    = r_state_q;
        w_data_d     = r_data_q;
        w_src_ctrl_d = r_src_ctrl_q;
`ifdef UART_TX_SCHED_GUARD_EN
        w_guard_cnt_d = r_guard_cnt_q;
`endif
        case (r_state_q)
            ST_IDLE: begin
                if (tx_en_i) begin
                    // Control characters bypass CTS so XOFF can always go out
                    if (ctrl_req_i) begin
                        w_data_d     = ctrl_data_i;
                        w_src_ctrl_d = 1'b1;
                        w_state_d    = ST_LOAD;
                    end else if (!fifo_empty_i && !cts_ni) begin
                        w_data_d     = fifo_data_i;
                        w_src_ctrl_d = 1'b0;
                        w_state_d    = ST_LOAD;
                    end
                end
            end
            ST_LOAD:  w_state_d = ST_START;
            ST_START: w_state_d = ST_WAIT_FI;
            ST_WAIT_FI: begin
                if (trans_fi_i) begin
`ifdef UART_TX_SCHED_GUARD_EN
                    if (guard_ticks_i == '0) begin
                        w_state_d = ST_IDLE;
                    end else begin
                        w_guard_cnt_d = '0;
                        w_state_d     = ST_GUARD;
                    end
`else
                    w_state_d = ST_IDLE;
`endif
                end
            end
`ifdef UART_TX_SCHED_GUARD_EN
            ST_GUARD: begin
                // Leave on the tick that brings the count to the target, so
                // IDLE follows the G-th tick by exactly one cycle
                if (tick_i) begin
                    w_guard_cnt_d = w_guard_inc[GUARD_W-1:0];
                    if (w_guard_inc >= {1'b0, guard_ticks_i}) begin
                        w_state_d = ST_IDLE;
                    end
                end
            end
`endif
            default: w_state_d = ST_IDLE;
        endcase

        // Outputs are derived from the state being entered so they are
        // registered and line up with the state they belong to
        w_fifo_rd_d  = (w_state_d == ST_LOAD) && !w_src_ctrl_d;
        w_ctrl_ack_d = (w_state_d == ST_LOAD) &&  w_src_ctrl_d;
        w_start_tx_d = (w_state_d == ST_START);
        w_busy_d     = (w_state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= ST_IDLE;
            r_data_q     <= 8'h00;
            r_src_ctrl_q <= 1'b0;
            r_fifo_rd_q  <= 1'b0;
            r_ctrl_ack_q <= 1'b0;
            r_start_tx_q <= 1'b0;
            r_busy_q     <= 1'b0;
`ifdef UART_TX_SCHED_GUARD_EN
            r_guard_cnt_q <= '0;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_data_q     <= w_data_d;
            r_src_ctrl_q <= w_src_ctrl_d;
            r_fifo_rd_q  <= w_fifo_rd_d;
            r_ctrl_ack_q <= w_ctrl_ack_d;
            r_start_tx_q <= w_start_tx_d;
            r_busy_q     <= w_busy_d;
`ifdef UART_TX_SCHED_GUARD_EN
            r_guard_cnt_q <= w_guard_cnt_d;
`endif
        end
    end

    assign fifo_rd_o  = r_fifo_rd_q;
    assign ctrl_ack_o = r_ctrl_ack_q;
    assign start_tx_o = r_start_tx_q;
    assign data_o     = r_data_q;
    assign busy_o     = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Purpose  : Directed self-checking bench for uart_tx_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_en_i;
    logic       fifo_empty_i;
    logic [7:0] fifo_data_i;
    logic       fifo_rd_o;
    logic       ctrl_req_i;
    logic [7:0] ctrl_data_i;
    logic       ctrl_ack_o;
    logic [3:0] guard_ticks_i;
    logic       tick_i;
    logic       cts_ni;
    logic       trans_fi_i;
    logic       start_tx_o;
    logic [7:0] data_o;
    logic       busy_o;

    int checks   = 0;
    int failures = 0;
    int n_rd     = 0;
    int n_ack    = 0;
    int n_start  = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.GUARD_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_en_i      (tx_en_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_rd_o    (fifo_rd_o),
        .ctrl_req_i   (ctrl_req_i),
        .ctrl_data_i  (ctrl_data_i),
        .ctrl_ack_o   (ctrl_ack_o),
        .guard_ticks_i(guard_ticks_i),
        .tick_i       (tick_i),
        .cts_ni       (cts_ni),
        .trans_fi_i   (trans_fi_i),
        .start_tx_o   (start_tx_o),
        .data_o       (data_o),
        .busy_o       (busy_o)
    );

    // Pulse counters, sampled on the edge that ends each pulse cycle
    always @(posedge clk) begin
        if (fifo_rd_o)  n_rd    <= n_rd + 1;
        if (ctrl_ack_o) n_ack   <= n_ack + 1;
        if (start_tx_o) n_start <= n_start + 1;
    end

    // Inputs change and outputs are observed on the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks += 5;
        if (fifo_rd_o !== 1'b0)  begin failures++; $display("FAIL reset_fifo_rd got=%b exp=0", fifo_rd_o); end
        if (ctrl_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ctrl_ack got=%b exp=0", ctrl_ack_o); end
        if (start_tx_o !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start_tx_o); end
        if (busy_o !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        if (data_o !== 8'h00)    begin failures++; $display("FAIL reset_data got=%h exp=00", data_o); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_fifo_grant();
        int rd0 = n_rd;
        fifo_empty_i = 1'b0; fifo_data_i = 8'hA5; cts_ni = 1'b0; tx_en_i = 1'b1;
        step();
        checks += 5;
        if (fifo_rd_o !== 1'b1)  begin failures++; $display("FAIL fifo_rd_n1 got=%b exp=1", fifo_rd_o); end
        if (ctrl_ack_o !== 1'b0) begin failures++; $display("FAIL fifo_ack_n1 got=%b exp=0", ctrl_ack_o); end
        if (start_tx_o !== 1'b0) begin failures++; $display("FAIL fifo_start_n1 got=%b exp=0", start_tx_o); end
        if (data_o !== 8'hA5)    begin failures++; $display("FAIL fifo_data got=%h exp=a5", data_o); end
        if (busy_o !== 1'b1)     begin failures++; $display("FAIL fifo_busy_n1 got=%b exp=1", busy_o); end
        fifo_empty_i = 1'b1;
        step();
        checks += 2;
        if (start_tx_o !== 1'b1) begin failures++; $display("FAIL fifo_start_n2 got=%b exp=1", start_tx_o); end
        if (fifo_rd_o !== 1'b0)  begin failures++; $display("FAIL fifo_rd_n2 got=%b exp=0", fifo_rd_o); end
        step();
        checks += 2;
        if (start_tx_o !== 1'b0) begin failures++; $display("FAIL fifo_start_n3 got=%b exp=0", start_tx_o); end
        if (busy_o !== 1'b1)     begin failures++; $display("FAIL fifo_busy_wait got=%b exp=1", busy_o); end
        trans_fi_i = 1'b1;
        step();
        trans_fi_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL fifo_busy_done got=%b exp=0", busy_o); end
        step();
        checks++;
        if (n_rd - rd0 !== 1) begin failures++; $display("FAIL fifo_rd_count got=%0d exp=1", n_rd - rd0); end
    endtask

    task automatic test_ctrl_priority();
        int rd0  = n_rd;
        int ack0 = n_ack;
        fifo_empty_i = 1'b0; fifo_data_i = 8'h5A; ctrl_req_i = 1'b1; ctrl_data_i = 8'h13;
        step();
        checks += 3;
        if (ctrl_ack_o !== 1'b1) begin failures++; $display("FAIL prio_ack got=%b exp=1", ctrl_ack_o); end
        if (fifo_rd_o !== 1'b0)  begin failures++; $display("FAIL prio_rd got=%b exp=0", fifo_rd_o); end
        if (data_o !== 8'h13)    begin failures++; $display("FAIL prio_data got=%h exp=13", data_o); end
        ctrl_req_i = 1'b0;
        step();
        checks++;
        if (start_tx_o !== 1'b1) begin failures++; $display("FAIL prio_start got=%b exp=1", start_tx_o); end
        step();
        trans_fi_i = 1'b1;
        step();
        trans_fi_i = 1'b0;
        checks++;
        if (fifo_rd_o !== 1'b0) begin failures++; $display("FAIL prio_idle_rd got=%b exp=0", fifo_rd_o); end
        step();
        checks += 2;
        if (fifo_rd_o !== 1'b1) begin failures++; $display("FAIL prio_fifo_rd got=%b exp=1", fifo_rd_o); end
        if (data_o !== 8'h5A)   begin failures++; $display("FAIL prio_fifo_data got=%h exp=5a", data_o); end
        fifo_empty_i = 1'b1;
        step();
        step();
        trans_fi_i = 1'b1;
        step();
        trans_fi_i = 1'b0;
        repeat (3) step();
        checks += 2;
        if (n_rd - rd0 !== 1)   begin failures++; $display("FAIL prio_rd_count got=%0d exp=1", n_rd - rd0); end
        if (n_ack - ack0 !== 1) begin failures++; $display("FAIL prio_ack_count got=%0d exp=1", n_ack - ack0); end
    endtask

    task automatic test_cts();
        int rd0 = n_rd;
        fifo_empty_i = 1'b0; fifo_data_i = 8'h3C; cts_ni = 1'b1;
        repeat (3) step();
        checks += 2;
        if (busy_o !== 1'b0)  begin failures++; $display("FAIL cts_block_busy got=%b exp=0", busy_o); end
        if (n_rd - rd0 !== 0) begin failures++; $display("FAIL cts_block_rd got=%0d exp=0", n_rd - rd0); end
        cts_ni = 1'b0;
        step();
        checks += 2;
        if (fifo_rd_o !== 1'b1) begin failures++; $display("FAIL cts_release_rd got=%b exp=1", fifo_rd_o); end
        if (data_o !== 8'h3C)   begin failures++; $display("FAIL cts_release_data got=%h exp=3c", data_o); end
        fifo_empty_i = 1'b1;
        step();
        step();
        trans_fi_i = 1'b1;
        step();
        trans_fi_i = 1'b0;
        cts_ni = 1'b1; ctrl_req_i = 1'b1; ctrl_data_i = 8'h11;
        step();
        checks += 2;
        if (ctrl_ack_o !== 1'b1) begin failures++; $display("FAIL cts_ctrl_ack got=%b exp=1", ctrl_ack_o); end
        if (data_o !== 8'h11)    begin failures++; $display("FAIL cts_ctrl_data got=%h exp=11", data_o); end
        ctrl_req_i = 1'b0;
        step();
        checks++;
        if (start_tx_o !== 1'b1) begin failures++; $display("FAIL cts_ctrl_start got=%b exp=1", start_tx_o); end
        step();
        trans_fi_i = 1'b1;
        step();
        trans_fi_i = 1'b0;
        cts_ni = 1'b0;
        step();
    endtask

    task automatic test_guard();
        int first_start = -1;
        int first_rd    = -1;
        logic busy_at13 = 1'bx;
        int exp_start;
        logic exp_busy13;
`ifdef UART_TX_SCHED_GUARD_EN
        exp_start  = 15;
        exp_busy13 = 1'b0;
`else
        exp_start  = 3;
        exp_busy13 = 1'b1;
`endif
        guard_ticks_i = 4'd3; tick_i = 1'b0;
        fifo_empty_i = 1'b0; fifo_data_i = 8'hB1;
        step();
        checks++;
        if (data_o !== 8'hB1) begin failures++; $display("FAIL guard_first_data got=%h exp=b1", data_o); end
        fifo_data_i = 8'hB2;
        step();
        step();
        for (int j = 0; j < 30; j++) begin
            trans_fi_i = (j == 0);
            tick_i     = (j > 0) && (j % 4 == 0);
            step();
            if (start_tx_o && first_start < 0) first_start = j + 1;
            if (fifo_rd_o && first_rd < 0)     first_rd = j + 1;
            if (j + 1 == 13)                   busy_at13 = busy_o;
        end
        trans_fi_i = 1'b0; tick_i = 1'b0;
        checks += 4;
        if (first_start !== exp_start)   begin failures++; $display("FAIL guard_start_cycle got=%0d exp=%0d", first_start, exp_start); end
        if (first_rd !== exp_start - 1)  begin failures++; $display("FAIL guard_rd_cycle got=%0d exp=%0d", first_rd, exp_start - 1); end
        if (busy_at13 !== exp_busy13)    begin failures++; $display("FAIL guard_busy13 got=%b exp=%b", busy_at13, exp_busy13); end
        if (data_o !== 8'hB2)            begin failures++; $display("FAIL guard_second_data got=%h exp=b2", data_o); end
        fifo_empty_i = 1'b1; guard_ticks_i = 4'd0;
        trans_fi_i = 1'b1;
        step();
        trans_fi_i = 1'b0;
        step();
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL guard_final_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_tx_en_drop();
        int rd0 = n_rd;
        fifo_empty_i = 1'b0; fifo_data_i = 8'hC3; tx_en_i = 1'b1;
        step();
        fifo_data_i = 8'hC4;
        step();
        step();
        tx_en_i = 1'b0;
        trans_fi_i = 1'b1;
        step();
        trans_fi_i = 1'b0;
        repeat (5) step();
        checks += 4;
        if (busy_o !== 1'b0)     begin failures++; $display("FAIL txen_busy got=%b exp=0", busy_o); end
        if (n_rd - rd0 !== 1)    begin failures++; $display("FAIL txen_rd_count got=%0d exp=1", n_rd - rd0); end
        if (data_o !== 8'hC3)    begin failures++; $display("FAIL txen_data got=%h exp=c3", data_o); end
        if (start_tx_o !== 1'b0) begin failures++; $display("FAIL txen_start got=%b exp=0", start_tx_o); end
        fifo_empty_i = 1'b1; tx_en_i = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        int st0 = n_start;
        fifo_empty_i = 1'b0; fifo_data_i = 8'hD7;
        step();
        fifo_empty_i = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks += 5;
        if (fifo_rd_o !== 1'b0)  begin failures++; $display("FAIL rstmid_rd got=%b exp=0", fifo_rd_o); end
        if (ctrl_ack_o !== 1'b0) begin failures++; $display("FAIL rstmid_ack got=%b exp=0", ctrl_ack_o); end
        if (start_tx_o !== 1'b0) begin failures++; $display("FAIL rstmid_start got=%b exp=0", start_tx_o); end
        if (busy_o !== 1'b0)     begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
        if (data_o !== 8'h00)    begin failures++; $display("FAIL rstmid_data got=%h exp=00", data_o); end
        trans_fi_i = 1'b1;
        step();
        trans_fi_i = 1'b0;
        step();
        step();
        checks += 2;
        if (busy_o !== 1'b0)     begin failures++; $display("FAIL spurious_fi_busy got=%b exp=0", busy_o); end
        if (n_start - st0 !== 1) begin failures++; $display("FAIL spurious_fi_starts got=%0d exp=1", n_start - st0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; tx_en_i = 1'b0; fifo_empty_i = 1'b1; fifo_data_i = 8'h00;
        ctrl_req_i = 1'b0; ctrl_data_i = 8'h00; guard_ticks_i = 4'd0; tick_i = 1'b0;
        cts_ni = 1'b0; trans_fi_i = 1'b0;
        test_reset();
        test_fifo_grant();
        test_ctrl_priority();
        test_cts();
        test_guard();
        test_tx_en_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
